// File: rtl/pir_alarm_sequencer.sv
// PIR motion alarm: synchronizer, debounce filter and DISARMED/ARMED/TRIGGERED/CAPTURE/COOLDOWN sequencer.
// Define PIR_ALARM_BUZZ_PULSE_EN to pulse the buzzer with a BUZZ_HALF_PERIOD square wave instead of a steady level.
module pir_alarm_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES  = 1000,
    parameter int unsigned CAPTURE_TIMEOUT  = 50000000,
    parameter int unsigned COOLDOWN_CYCLES  = 100000000,
    parameter int unsigned BUZZ_HALF_PERIOD = 25000
) (
    input  logic        s00_axi_aclk,
    input  logic        s00_axi_aresetn,
    input  logic        pir_in,
    input  logic        arm,
    input  logic        clear_alarm,
    input  logic        capture_done,
    output logic        led,
    output logic        buzzer,
    output logic        enable_capture,
    output logic        alarm_active,
    output logic        timeout_flag,
    output logic [15:0] event_count,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        ST_DISARMED  = 3'd0,
        ST_ARMED     = 3'd1,
        ST_TRIGGERED = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_COOLDOWN  = 3'd4
    } state_e;

    localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] CAP_LAST  = 32'(CAPTURE_TIMEOUT - 1);
    localparam logic [31:0] COOL_LAST = 32'(COOLDOWN_CYCLES - 1);

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        pir_db_q, pir_db_d;
    logic        pir_db_dly_q, pir_db_dly_d;
    logic [15:0] db_cnt_q, db_cnt_d;
    state_e      state_q, state_d;
    logic [31:0] phase_q, phase_d;
    logic [15:0] event_count_q, event_count_d;
    logic        timeout_flag_q, timeout_flag_d;
    logic        led_q, led_d;
    logic        buzzer_q, buzzer_d;
    logic        enable_capture_q, enable_capture_d;
    logic        alarm_active_q, alarm_active_d;
    logic        trigger;
    logic        timeout_hit;
`ifdef PIR_ALARM_BUZZ_PULSE_EN
    localparam logic [23:0] BUZZ_LAST = 24'(BUZZ_HALF_PERIOD - 1);
    logic [23:0] buzz_cnt_q, buzz_cnt_d;
`endif

    always_comb begin
        sync1_d      = pir_in;
        sync2_d      = sync1_q;
        pir_db_dly_d = pir_db_q;

        pir_db_d = pir_db_q;
        db_cnt_d = '0;
        if (sync2_q != pir_db_q) begin
            if (db_cnt_q == DB_LAST) pir_db_d = sync2_q;
            else                     db_cnt_d = db_cnt_q + 16'd1;
        end

        // Registered edge detect puts TRIGGERED one cycle after the filtered level rises.
        trigger = pir_db_q & ~pir_db_dly_q;

        state_d       = state_q;
        phase_d       = phase_q;
        event_count_d = event_count_q;
        timeout_hit   = 1'b0;
        if (!arm) begin
            state_d = ST_DISARMED;
        end else if (clear_alarm && (state_q inside {ST_TRIGGERED, ST_CAPTURE, ST_COOLDOWN})) begin
            state_d = ST_ARMED;
        end else begin
            case (state_q)
                ST_DISARMED: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (trigger) begin
                        state_d = ST_TRIGGERED;
                        if (event_count_q != 16'hFFFF) event_count_d = event_count_q + 16'd1;
                    end
                end
                ST_TRIGGERED: begin
                    state_d = ST_CAPTURE;
                    phase_d = '0;
                end
                ST_CAPTURE: begin
                    if (capture_done) begin
                        state_d = ST_COOLDOWN;
                        phase_d = '0;
                    end else if (phase_q == CAP_LAST) begin
                        state_d     = ST_COOLDOWN;
                        phase_d     = '0;
                        timeout_hit = 1'b1;
                    end else begin
                        phase_d = phase_q + 32'd1;
                    end
                end
                ST_COOLDOWN: begin
                    if (phase_q == COOL_LAST) state_d = ST_ARMED;
                    else                      phase_d = phase_q + 32'd1;
                end
                default: state_d = ST_DISARMED;
            endcase
        end

        timeout_flag_d = clear_alarm ? 1'b0 : (timeout_flag_q | timeout_hit);

        led_d            = state_q inside {ST_TRIGGERED, ST_CAPTURE, ST_COOLDOWN};
        alarm_active_d   = state_q inside {ST_TRIGGERED, ST_CAPTURE};
        enable_capture_d = (state_q == ST_CAPTURE);
`ifdef PIR_ALARM_BUZZ_PULSE_EN
        buzzer_d   = 1'b0;
        buzz_cnt_d = '0;
        if (state_q == ST_TRIGGERED) begin
            buzzer_d = 1'b1;
        end else if (state_q == ST_CAPTURE) begin
            if (buzz_cnt_q == BUZZ_LAST) begin
                buzzer_d = ~buzzer_q;
            end else begin
                buzzer_d   = buzzer_q;
                buzz_cnt_d = buzz_cnt_q + 24'd1;
            end
        end
`else
        buzzer_d = alarm_active_d;
`endif
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            sync1_q          <= 1'b0;
            sync2_q          <= 1'b0;
            pir_db_q         <= 1'b0;
            pir_db_dly_q     <= 1'b0;
            db_cnt_q         <= '0;
            state_q          <= ST_DISARMED;
            phase_q          <= '0;
            event_count_q    <= '0;
            timeout_flag_q   <= 1'b0;
            led_q            <= 1'b0;
            buzzer_q         <= 1'b0;
            enable_capture_q <= 1'b0;
            alarm_active_q   <= 1'b0;
`ifdef PIR_ALARM_BUZZ_PULSE_EN
            buzz_cnt_q       <= '0;
`endif
        end else begin
            sync1_q          <= sync1_d;
            sync2_q          <= sync2_d;
            pir_db_q         <= pir_db_d;
            pir_db_dly_q     <= pir_db_dly_d;
            db_cnt_q         <= db_cnt_d;
            state_q          <= state_d;
            phase_q          <= phase_d;
            event_count_q    <= event_count_d;
            timeout_flag_q   <= timeout_flag_d;
            led_q            <= led_d;
            buzzer_q         <= buzzer_d;
            enable_capture_q <= enable_capture_d;
            alarm_active_q   <= alarm_active_d;
`ifdef PIR_ALARM_BUZZ_PULSE_EN
            buzz_cnt_q       <= buzz_cnt_d;
`endif
        end
    end

    assign led            = led_q;
    assign buzzer         = buzzer_q;
    assign enable_capture = enable_capture_q;
    assign alarm_active   = alarm_active_q;
    assign timeout_flag   = timeout_flag_q;
    assign event_count    = event_count_q;
    assign state          = state_q;

endmodule

// File: doc/pir_alarm_sequencer.md
PIR_ALARM_SEQUENCER -- requirements
Module: pir_alarm_sequencer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000, meaning the consecutive stable cycles required before the filtered PIR level changes (range 1..65535).
REQ-002 The block SHALL have parameter CAPTURE_TIMEOUT, default 50000000, meaning the maximum cycles spent in CAPTURE awaiting capture_done (range 1..2^32-1).
REQ-003 The block SHALL have parameter COOLDOWN_CYCLES, default 100000000, meaning the cycles spent in COOLDOWN (range 1..2^32-1).
REQ-004 The block SHALL have parameter BUZZ_HALF_PERIOD, default 25000, meaning the buzzer toggle half-period in cycles (range 1..2^24-1); it is used only under REQ-024.
REQ-005 The block SHALL have one clock and synchronous active-low reset: s00_axi_aclk in 1 (rising-edge clock); s00_axi_aresetn in 1 (synchronous, active-low).
REQ-006 The block SHALL have these ports:
- pir_in in 1: raw asynchronous PIR sensor level.
- arm in 1: level from the control register; 1 = system armed.
- clear_alarm in 1: single-cycle pulse that acknowledges or aborts an alarm.
- capture_done in 1: single-cycle pulse from the camera capture path.
- led out 1: alarm indicator.
- buzzer out 1: buzzer drive.
- enable_capture out 1: camera capture enable.
- alarm_active out 1: high in TRIGGERED or CAPTURE.
- timeout_flag out 1: sticky flag; capture timed out.
- event_count out 16: count of PIR triggers.
- state out 3: current state encoding.

Function
REQ-007 pir_in SHALL pass through a 2-flop synchronizer before any other use.
REQ-008 The debounce filter:
- Counter: 16-bit; increments each cycle the synchronized value differs from pir_db; clears when they are equal.
- Update: pir_db takes the synchronized value on the cycle the counter reaches DEBOUNCE_CYCLES-1; the counter clears on the same cycle.
REQ-009 A trigger SHALL be a 0->1 transition of pir_db. Pulses shorter than DEBOUNCE_CYCLES cycles SHALL never produce a trigger.
REQ-010 The state encoding SHALL be: DISARMED=0, ARMED=1, TRIGGERED=2, CAPTURE=3, COOLDOWN=4. Codes 5-7 are unreachable; if ever present, the next state SHALL be DISARMED.
REQ-011 Transition priority each cycle SHALL be: (1) arm=0 -> DISARMED from any state; (2) clear_alarm=1 in TRIGGERED, CAPTURE or COOLDOWN -> ARMED; (3) the normal transitions in REQ-012 to REQ-015.
REQ-012 DISARMED -> ARMED SHALL occur when arm=1. Triggers in DISARMED SHALL be ignored and not counted.
REQ-013 ARMED -> TRIGGERED SHALL occur on a trigger. event_count SHALL increment in the same cycle, saturating at 0xFFFF.
REQ-014 TRIGGERED SHALL last exactly one cycle, then go to CAPTURE. On entry to CAPTURE, the 32-bit phase counter SHALL clear.
REQ-015 CAPTURE exits:
- To COOLDOWN on capture_done=1.
- Otherwise to COOLDOWN when the phase counter reaches CAPTURE_TIMEOUT-1; timeout_flag SHALL set in that cycle.
- If capture_done and timeout occur in the same cycle, capture_done wins and timeout_flag is not set.
REQ-016 COOLDOWN:
- Lasts COOLDOWN_CYCLES cycles, counted by the phase counter, which clears on entry.
- Then goes to ARMED (arm is necessarily 1 per REQ-011).
- Triggers during COOLDOWN SHALL be ignored and not counted.
REQ-017 capture_done outside CAPTURE SHALL be ignored.
REQ-018 All outputs SHALL be registered and decoded from the current state. Each output SHALL be valid one cycle after the state register updates:
- led = 1 in TRIGGERED, CAPTURE, COOLDOWN.
- buzzer = 1 in TRIGGERED, CAPTURE.
- enable_capture = 1 in CAPTURE only.
- alarm_active = 1 in TRIGGERED, CAPTURE.
REQ-019 timeout_flag SHALL clear only on clear_alarm=1 or on reset. If a timeout and clear_alarm occur in the same cycle, the clear wins.
REQ-020 Latency: a clean pir_in rise in ARMED SHALL reach state=TRIGGERED 2+DEBOUNCE_CYCLES+1 cycles later (±1 for synchronizer sampling).

Reset
REQ-021 While s00_axi_aresetn=0 at a clock edge, all of the following SHALL be 0 and state SHALL be DISARMED: state, pir_db, synchronizer flops, debounce counter, phase counter, event_count, timeout_flag, led, buzzer, enable_capture, alarm_active.
REQ-022 Reset asserted mid-CAPTURE SHALL drop enable_capture and buzzer on the first reset edge.
REQ-023 After release, a trigger SHALL require a fresh debounce period.

Configuration
REQ-024 With PIR_ALARM_BUZZ_PULSE_EN defined:
- buzzer SHALL toggle every BUZZ_HALF_PERIOD cycles while in TRIGGERED or CAPTURE, starting at 1 on entry to TRIGGERED.
- buzzer SHALL be 0 in all other states.
- A 24-bit toggle counter is added.
REQ-025 Without PIR_ALARM_BUZZ_PULSE_EN, buzzer SHALL be a steady level per REQ-018, and no toggle counter SHALL exist.

Verification
Bench parameters: DEBOUNCE_CYCLES=4, CAPTURE_TIMEOUT=20, COOLDOWN_CYCLES=8, BUZZ_HALF_PERIOD=3.
REQ-026 arm=1, then pir_in high 3 cycles -> no trigger; state stays 1; event_count=0.
REQ-027 arm=1, pir_in held high, capture_done pulse 5 cycles after CAPTURE entry:
- state sequence 1->2->3->4->1;
- enable_capture high exactly 5 cycles;
- led high through COOLDOWN (8 cycles);
- event_count=1; timeout_flag=0.
REQ-028 Trigger, no capture_done -> CAPTURE lasts 20 cycles; timeout_flag=1 on exit; a later clear_alarm pulse -> timeout_flag=0.
REQ-029 arm dropped in the same cycle as capture_done during CAPTURE -> next state=0; all outputs 0.
REQ-030 s00_axi_aresetn=0 for 1 cycle mid-CAPTURE with event_count=3 -> event_count=0, state=0, enable_capture=0 after that edge.
REQ-031 With PIR_ALARM_BUZZ_PULSE_EN defined, trigger -> buzzer pattern 1,1,1,0,0,0,1,... during CAPTURE; buzzer=0 in COOLDOWN.
